// File: rtl/clks_pkg.sv
// Shared types and defaults for the clock/reset control blocks.
package clks_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    RELEASE   = 3'd1,
    RUN       = 3'd2,
    SW_HOLD   = 3'd3
  } seq_state_t;

  localparam int DEF_STAGE_DELAY = 16;
  localparam int DEF_LOCK_STABLE = 64;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop bit synchronizer with asynchronous active-low clear.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic r_meta;
  (* ASYNC_REG = "TRUE" *) logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Releases the local reset domains in order once PLL lock is stable.
//   state     | meaning
//   WAIT_LOCK | counting consecutive synchronized lock-high cycles
//   RELEASE   | deasserting one stage per STAGE_DELAY cycles
//   RUN       | all stages released, servicing software requests
//   SW_HOLD   | all stages reasserted for STAGE_DELAY cycles
module reset_sequencer
  import clks_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DELAY = DEF_STAGE_DELAY,
  parameter int LOCK_STABLE = DEF_LOCK_STABLE
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  pll_locked,
  input  logic                  sw_rst_req,
  output logic                  sw_rst_ack,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  all_released,
  output logic [2:0]            seq_state
);

  localparam int CNT_W = $clog2(max_i(LOCK_STABLE, STAGE_DELAY));
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0] LOCK_TC  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] STAGE_TC = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  logic r_rst_meta;
  logic r_rst_n;
  logic w_lock_s;
  logic w_sw_s;
  logic r_sw_prev;
  logic w_sw_rise;

  seq_state_t            r_state,     w_state_nxt;
  logic [CNT_W-1:0]      r_cnt,       w_cnt_nxt;
  logic [IDX_W-1:0]      r_idx,       w_idx_nxt;
  logic [NUM_STAGES-1:0] r_stage_rst, w_stage_nxt;
  logic                  r_pend,      w_pend_nxt;
  logic                  r_sw_flag,   w_flag_nxt;
  logic                  r_ack,       w_ack_nxt;

  // Assertion is immediate; only the release edge is retimed to clk.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_n    <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_n    <= r_rst_meta;
    end
  end

  sync_2ff u_sync_lock (
    .i_clk   (clk),
    .i_rst_n (r_rst_n),
    .i_d     (pll_locked),
    .o_q     (w_lock_s)
  );

  sync_2ff u_sync_sw (
    .i_clk   (clk),
    .i_rst_n (r_rst_n),
    .i_d     (sw_rst_req),
    .o_q     (w_sw_s)
  );

  assign w_sw_rise = w_sw_s & ~r_sw_prev;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_stage_nxt = r_stage_rst;
    w_pend_nxt  = r_pend;
    w_flag_nxt  = r_sw_flag;
    w_ack_nxt   = 1'b0;

    // Edges arriving during the hold are folded into the sequence in progress.
    if (w_sw_rise && (r_state != SW_HOLD))
      w_pend_nxt = 1'b1;

    if (!w_lock_s) begin
      w_state_nxt = WAIT_LOCK;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_stage_nxt = '1;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          if (r_cnt == LOCK_TC) begin
            w_state_nxt = RELEASE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (r_cnt == STAGE_TC) begin
            w_cnt_nxt = '0;
            for (int i = 0; i < NUM_STAGES; i++)
              if (r_idx == IDX_W'(i)) w_stage_nxt[i] = 1'b0;
            if (r_idx == LAST_IDX) begin
              w_state_nxt = RUN;
              w_idx_nxt   = '0;
              w_ack_nxt   = r_sw_flag;
              w_flag_nxt  = 1'b0;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (r_pend) begin
            w_state_nxt = SW_HOLD;
            w_cnt_nxt   = '0;
            w_stage_nxt = '1;
            w_pend_nxt  = 1'b0;
            w_flag_nxt  = 1'b1;
          end
        end
        SW_HOLD: begin
          if (r_cnt == STAGE_TC) begin
            w_state_nxt = RELEASE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_stage_nxt = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_state     <= WAIT_LOCK;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_stage_rst <= '1;
      r_pend      <= 1'b0;
      r_sw_flag   <= 1'b0;
      r_ack       <= 1'b0;
      r_sw_prev   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_stage_rst <= w_stage_nxt;
      r_pend      <= w_pend_nxt;
      r_sw_flag   <= w_flag_nxt;
      r_ack       <= w_ack_nxt;
      r_sw_prev   <= w_sw_s;
    end
  end

  assign stage_rst    = r_stage_rst;
  assign all_released = ~|r_stage_rst;
  assign sw_rst_ack   = r_ack;
  assign seq_state    = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters.
module tb_reset_sequencer;

  logic       clk;
  logic       arst_n;
  logic       pll_locked;
  logic       sw_rst_req;
  logic       sw_rst_ack;
  logic [2:0] stage_rst;
  logic       all_released;
  logic [2:0] seq_state;

  int total = 0;
  int bad   = 0;
  int acks  = 0;

  reset_sequencer dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .pll_locked   (pll_locked),
    .sw_rst_req   (sw_rst_req),
    .sw_rst_ack   (sw_rst_ack),
    .stage_rst    (stage_rst),
    .all_released (all_released),
    .seq_state    (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (sw_rst_ack === 1'b1) acks++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    arst_n     = 1'b0;
    pll_locked = 1'b1;
    sw_rst_req = 1'b0;

    // power-up: lock_s first high after the 4th edge following arst_n release
    cyc(1);
    chk("rst_stage", 32'(stage_rst), 32'd7);
    chk("rst_allrel", 32'(all_released), 32'd0);
    chk("rst_ack", 32'(sw_rst_ack), 32'd0);
    chk("rst_state", 32'(seq_state), 32'd0);
    cyc(4);
    chk("rst_stage_hold", 32'(stage_rst), 32'd7);
    arst_n = 1'b1;
    cyc(83);
    chk("pu_pre0", 32'(stage_rst), 32'd7);
    chk("pu_state_rel", 32'(seq_state), 32'd1);
    cyc(1);
    chk("pu_rel0", 32'(stage_rst), 32'd6);
    cyc(15);
    chk("pu_pre1", 32'(stage_rst), 32'd6);
    cyc(1);
    chk("pu_rel1", 32'(stage_rst), 32'd4);
    cyc(15);
    chk("pu_pre2_allrel", 32'(all_released), 32'd0);
    cyc(1);
    chk("pu_rel2", 32'(stage_rst), 32'd0);
    chk("pu_allrel", 32'(all_released), 32'd1);
    chk("pu_run", 32'(seq_state), 32'd2);
    chk("pu_no_ack", 32'(acks), 32'd0);

    // lock loss in RUN: outputs reassert on the third edge
    pll_locked = 1'b0;
    cyc(2);
    chk("ll_pre", 32'(stage_rst), 32'd0);
    cyc(1);
    chk("ll_stage", 32'(stage_rst), 32'd7);
    chk("ll_allrel", 32'(all_released), 32'd0);
    chk("ll_state", 32'(seq_state), 32'd0);
    cyc(3);

    // relock, then a one-cycle glitch of lock_s after ~40 high cycles
    pll_locked = 1'b1;
    cyc(42);
    pll_locked = 1'b0;
    cyc(1);
    pll_locked = 1'b1;
    cyc(39);
    chk("gl_orig_time", 32'(stage_rst), 32'd7);
    cyc(42);
    chk("gl_pre0", 32'(stage_rst), 32'd7);
    cyc(1);
    chk("gl_rel0", 32'(stage_rst), 32'd6);
    cyc(16);
    chk("gl_rel1", 32'(stage_rst), 32'd4);
    cyc(16);
    chk("gl_rel2", 32'(stage_rst), 32'd0);
    chk("gl_allrel", 32'(all_released), 32'd1);
    chk("gl_run", 32'(seq_state), 32'd2);
    chk("gl_no_ack", 32'(acks), 32'd0);

    // software reset with a second edge 5 cycles later (merged)
    sw_rst_req = 1'b1;
    cyc(2);
    sw_rst_req = 1'b0;
    cyc(1);
    chk("sw_pre", 32'(stage_rst), 32'd0);
    chk("sw_pre_state", 32'(seq_state), 32'd2);
    cyc(1);
    chk("sw_hold_stage", 32'(stage_rst), 32'd7);
    chk("sw_hold_state", 32'(seq_state), 32'd3);
    chk("sw_hold_allrel", 32'(all_released), 32'd0);
    cyc(1);
    sw_rst_req = 1'b1;
    cyc(2);
    sw_rst_req = 1'b0;
    cyc(28);
    chk("sw_pre0", 32'(stage_rst), 32'd7);
    chk("sw_state_rel", 32'(seq_state), 32'd1);
    cyc(1);
    chk("sw_rel0", 32'(stage_rst), 32'd6);
    cyc(16);
    chk("sw_rel1", 32'(stage_rst), 32'd4);
    cyc(15);
    chk("sw_pre2", 32'(stage_rst), 32'd4);
    chk("sw_no_early_ack", 32'(acks), 32'd0);
    cyc(1);
    chk("sw_rel2", 32'(stage_rst), 32'd0);
    chk("sw_ack", 32'(sw_rst_ack), 32'd1);
    chk("sw_run", 32'(seq_state), 32'd2);
    cyc(1);
    chk("sw_ack_1cyc", 32'(sw_rst_ack), 32'd0);
    cyc(60);
    chk("mg_one_ack", 32'(acks), 32'd1);
    chk("mg_stage", 32'(stage_rst), 32'd0);
    chk("mg_run", 32'(seq_state), 32'd2);

    // request during RELEASE stays pending until RUN
    pll_locked = 1'b0;
    cyc(3);
    chk("pd_wait", 32'(seq_state), 32'd0);
    pll_locked = 1'b1;
    cyc(90);
    chk("pd_rel0", 32'(stage_rst), 32'd6);
    sw_rst_req = 1'b1;
    cyc(2);
    sw_rst_req = 1'b0;
    cyc(21);
    chk("pd_pre2", 32'(stage_rst), 32'd4);
    chk("pd_pre2_state", 32'(seq_state), 32'd1);
    cyc(1);
    chk("pd_run_stage", 32'(stage_rst), 32'd0);
    chk("pd_run_state", 32'(seq_state), 32'd2);
    chk("pd_no_lock_ack", 32'(acks), 32'd1);
    cyc(1);
    chk("pd_hold_state", 32'(seq_state), 32'd3);
    chk("pd_hold_stage", 32'(stage_rst), 32'd7);
    cyc(64);
    chk("pd_ack", 32'(sw_rst_ack), 32'd1);
    chk("pd_acks", 32'(acks), 32'd2);
    chk("pd_done", 32'(stage_rst), 32'd0);

    // async reset at idx=1 of a software sequence
    sw_rst_req = 1'b1;
    cyc(2);
    sw_rst_req = 1'b0;
    cyc(2);
    chk("ar_hold", 32'(seq_state), 32'd3);
    cyc(32);
    chk("ar_idx1", 32'(stage_rst), 32'd6);
    cyc(5);
    arst_n = 1'b0;
    #2;
    chk("ar_imm_stage", 32'(stage_rst), 32'd7);
    chk("ar_imm_allrel", 32'(all_released), 32'd0);
    chk("ar_imm_state", 32'(seq_state), 32'd0);
    cyc(3);
    arst_n = 1'b1;
    cyc(83);
    chk("ar_pre0", 32'(stage_rst), 32'd7);
    cyc(1);
    chk("ar_rel0", 32'(stage_rst), 32'd6);
    cyc(32);
    chk("ar_rel2", 32'(stage_rst), 32'd0);
    chk("ar_allrel", 32'(all_released), 32'd1);
    chk("ar_no_ack", 32'(acks), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
